// File: rtl/pe_stream_macc.sv
// pe_stream_macc: integer stream processing element for the CGRA fabric.
//
// Element-wise ops (add, mul, multiply-add) emit one result per fired beat.
// Packet reductions (accumulate, dot product) emit one result on the beat
// carrying tlast. The op is latched on a packet's first beat. Every op goes
// through the same pipeline, so each result appears exactly MUL_LAT+1 cycles
// after its beat fires, whatever the op.
//
// Optional feature macro: PE_SAT_EN
//   defined   : add/mul/macc/acc/dot results clamp to the signed DWIDTH range
//   undefined : all results wrap modulo 2^DWIDTH (no saturation logic)
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   inp1, inp2                  stream operands A and B
//   inp3                        static addend C for macc, sampled per beat
//   t_valid_inp1, t_valid_inp2  operand valids
//   t_last1_in, t_last2_in      last-beat flags from the two sources
//   op                          000 add, 001 acc, 010 mul, 011 macc, 100 dot
//   out, t_valid_out            result and its valid
//   t_last_out                  result is the last of its packet
//   busy                        packet open or a beat still in the pipeline
module pe_stream_macc #(
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] inp1,
    input  logic [DWIDTH-1:0] inp2,
    input  logic [DWIDTH-1:0] inp3,
    input  logic              t_valid_inp1,
    input  logic              t_valid_inp2,
    input  logic              t_last1_in,
    input  logic              t_last2_in,
    input  logic [2:0]        op,
    output logic [DWIDTH-1:0] out,
    output logic              t_valid_out,
    output logic              t_last_out,
    output logic              busy
);

`ifdef PE_SAT_EN
    // Full product and two guard bits so no intermediate sum can overflow.
    localparam int unsigned PW = 2 * DWIDTH;
    localparam int unsigned EW = 2 * DWIDTH + 2;
    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {{(EW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};
`else
    // Wrapping results only ever need the low DWIDTH bits.
    localparam int unsigned PW = DWIDTH;
    localparam int unsigned EW = DWIDTH;
`endif
    localparam int unsigned NS = MUL_LAT;
    localparam int unsigned LS = NS - 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ACC  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_MACC = 3'b011;
    localparam logic [2:0] OP_DOT  = 3'b100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        pkt_op_q, pkt_op_d;
    logic [2:0]        eff_op_c;
    logic              fire_c, last_c, first_c;
    logic              busy_q, busy_d;

    logic              stg_v_q     [NS];
    logic              stg_last_q  [NS];
    logic              stg_first_q [NS];
    logic [2:0]        stg_op_q    [NS];
    logic [DWIDTH-1:0] stg_a_q     [NS];
    logic [DWIDTH-1:0] stg_b_q     [NS];
    logic [DWIDTH-1:0] stg_c_q     [NS];
    logic [PW-1:0]     stg_p_q     [NS];

    logic signed [PW-1:0] prod_c;

    logic [DWIDTH-1:0] acc_q, acc_d;
    logic [DWIDTH-1:0] out_q, out_d;
    logic              t_valid_q, t_valid_d;
    logic              t_last_q, t_last_d;

    logic signed [DWIDTH-1:0] fa_s, fb_s, fc_s, base_s;
    logic signed [PW-1:0]     fp_s;
    logic signed [EW-1:0]     add_w, mul_w, macc_w, acc_w, dot_w;
    logic [DWIDTH-1:0]        res_c;
    logic                     emit_c;

    // Reduce a wide signed result to DWIDTH bits (clamp or wrap).
    function automatic logic [DWIDTH-1:0] fit(input logic signed [EW-1:0] v);
        logic [DWIDTH-1:0] r;
`ifdef PE_SAT_EN
        if (v > SAT_MAX) begin
            r = SAT_MAX[DWIDTH-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[DWIDTH-1:0];
        end else begin
            r = v[DWIDTH-1:0];
        end
`else
        r = v;
`endif
        return r;
    endfunction

    // Packet tracking: live op on the first beat, latched op afterwards.
    always_comb begin
        state_d  = state_q;
        pkt_op_d = pkt_op_q;
        eff_op_c = (state_q == ST_IDLE) ? op : pkt_op_q;
        fire_c   = (eff_op_c == OP_ACC) ? t_valid_inp1 : (t_valid_inp1 & t_valid_inp2);
        last_c   = (t_last1_in | t_last2_in) & fire_c;
        first_c  = (state_q == ST_IDLE);
        if (fire_c) begin
            if (state_q == ST_IDLE) begin
                pkt_op_d = op;
            end
            state_d = last_c ? ST_IDLE : ST_OPEN;
        end
        // busy is registered: it reflects next cycle's open state and stage valids.
        busy_d = (state_d == ST_OPEN) | fire_c;
        for (int unsigned i = 0; i + 1 < NS; i++) begin
            busy_d = busy_d | stg_v_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pkt_op_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            pkt_op_q <= pkt_op_d;
        end
    end

    assign prod_c = PW'($signed(inp1)) * PW'($signed(inp2));

    // Delay line: beat attributes and operands travel alongside the product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NS; i++) begin
                stg_v_q[i]     <= 1'b0;
                stg_last_q[i]  <= 1'b0;
                stg_first_q[i] <= 1'b0;
                stg_op_q[i]    <= 3'b000;
                stg_a_q[i]     <= '0;
                stg_b_q[i]     <= '0;
                stg_c_q[i]     <= '0;
                stg_p_q[i]     <= '0;
            end
        end else begin
            stg_v_q[0]     <= fire_c;
            stg_last_q[0]  <= last_c;
            stg_first_q[0] <= first_c;
            stg_op_q[0]    <= eff_op_c;
            stg_a_q[0]     <= inp1;
            stg_b_q[0]     <= inp2;
            stg_c_q[0]     <= inp3;
            stg_p_q[0]     <= prod_c;
            for (int unsigned i = 1; i < NS; i++) begin
                stg_v_q[i]     <= stg_v_q[i-1];
                stg_last_q[i]  <= stg_last_q[i-1];
                stg_first_q[i] <= stg_first_q[i-1];
                stg_op_q[i]    <= stg_op_q[i-1];
                stg_a_q[i]     <= stg_a_q[i-1];
                stg_b_q[i]     <= stg_b_q[i-1];
                stg_c_q[i]     <= stg_c_q[i-1];
                stg_p_q[i]     <= stg_p_q[i-1];
            end
        end
    end

    // Final-stage operands; the first beat of a packet starts from zero.
    assign fa_s   = $signed(stg_a_q[LS]);
    assign fb_s   = $signed(stg_b_q[LS]);
    assign fc_s   = $signed(stg_c_q[LS]);
    assign fp_s   = $signed(stg_p_q[LS]);
    assign base_s = stg_first_q[LS] ? '0 : $signed(acc_q);

    assign add_w  = EW'(fa_s) + EW'(fb_s);
    assign mul_w  = EW'(fp_s);
    assign macc_w = EW'(fp_s) + EW'(fc_s);
    assign acc_w  = EW'(base_s) + EW'(fa_s);
    assign dot_w  = EW'(base_s) + EW'(fp_s);

    // Result select; reductions update the accumulator every beat, emit on last.
    always_comb begin
        acc_d     = acc_q;
        out_d     = out_q;
        t_valid_d = 1'b0;
        t_last_d  = 1'b0;
        res_c     = '0;
        emit_c    = 1'b0;
        if (stg_v_q[LS]) begin
            case (stg_op_q[LS])
                OP_ADD: begin
                    res_c  = fit(add_w);
                    emit_c = 1'b1;
                end
                OP_MUL: begin
                    res_c  = fit(mul_w);
                    emit_c = 1'b1;
                end
                OP_MACC: begin
                    res_c  = fit(macc_w);
                    emit_c = 1'b1;
                end
                OP_ACC: begin
                    res_c  = fit(acc_w);
                    acc_d  = res_c;
                    emit_c = stg_last_q[LS];
                end
                OP_DOT: begin
                    res_c  = fit(dot_w);
                    acc_d  = res_c;
                    emit_c = stg_last_q[LS];
                end
                default: begin
                    emit_c = 1'b0;
                end
            endcase
        end
        if (emit_c) begin
            out_d     = res_c;
            t_valid_d = 1'b1;
            t_last_d  = stg_last_q[LS];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            out_q     <= '0;
            t_valid_q <= 1'b0;
            t_last_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            out_q     <= out_d;
            t_valid_q <= t_valid_d;
            t_last_q  <= t_last_d;
            busy_q    <= busy_d;
        end
    end

    assign out         = out_q;
    assign t_valid_out = t_valid_q;
    assign t_last_out  = t_last_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pe_stream_macc.sv
// Bench for pe_stream_macc: directed cases then randomized traffic, scored
// against a packet-level reference model through an expectation queue.
module tb_pe_stream_macc;

    localparam int unsigned DW  = 32;
    localparam int unsigned ML  = 4;
    localparam int          LAT = ML + 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ACC  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_MACC = 3'b011;
    localparam logic [2:0] OP_DOT  = 3'b100;
    localparam logic [2:0] OP_NOP  = 3'b111;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] inp1, inp2, inp3;
    logic          t_valid_inp1, t_valid_inp2, t_last1_in, t_last2_in;
    logic [2:0]    op;
    logic [DW-1:0] out;
    logic          t_valid_out, t_last_out, busy;

    pe_stream_macc #(.DWIDTH(DW), .MUL_LAT(ML)) dut (
        .clk          (clk),
        .rst          (rst),
        .inp1         (inp1),
        .inp2         (inp2),
        .inp3         (inp3),
        .t_valid_inp1 (t_valid_inp1),
        .t_valid_inp2 (t_valid_inp2),
        .t_last1_in   (t_last1_in),
        .t_last2_in   (t_last2_in),
        .op           (op),
        .out          (out),
        .t_valid_out  (t_valid_out),
        .t_last_out   (t_last_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] val;
        bit            last;
        int            due;
    } exp_t;

    exp_t scb[$];
    exp_t e;

    int checks   = 0;
    int failures = 0;

    // Reference model state: packet open flag, latched op, running sum.
    bit         m_open      = 1'b0;
    logic [2:0] m_op        = 3'b000;
    longint     m_acc       = 0;
    int         m_last_fire = -100;
    logic [DW-1:0] last_out = '0;

    function automatic longint fit(input longint v);
`ifdef PE_SAT_EN
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
`else
        return longint'(int'(v));
`endif
    endfunction

    function automatic void chk(input string nm, input longint act, input longint exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp_v);
        end
    endfunction

    function automatic void push(input longint r, input bit l);
        exp_t x;
        x.val  = DW'(r);
        x.last = l;
        x.due  = cyc + LAT;
        scb.push_back(x);
    endfunction

    // Behavioural model of one input cycle, applied when the inputs are driven.
    function automatic void model_step(input bit v1, input bit v2,
                                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                                       input logic [DW-1:0] c, input bit l1, input bit l2,
                                       input logic [2:0] o);
        logic [2:0] eff;
        bit         fire, last, first;
        longint     sa, sbv, sc, term;
        eff  = m_open ? m_op : o;
        fire = (eff == OP_ACC) ? v1 : (v1 && v2);
        if (!fire) return;
        last  = l1 || l2;
        first = !m_open;
        if (first) m_op = o;
        m_last_fire = cyc;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        sc  = longint'($signed(c));
        case (eff)
            OP_ADD:  push(fit(sa + sbv), last);
            OP_MUL:  push(fit(sa * sbv), last);
            OP_MACC: push(fit(sa * sbv + sc), last);
            OP_ACC, OP_DOT: begin
                term  = (eff == OP_ACC) ? sa : sa * sbv;
                m_acc = fit((first ? 64'sd0 : m_acc) + term);
                if (last) push(m_acc, 1'b1);
            end
            default: ;
        endcase
        m_open = !last;
    endfunction

    task automatic drive(input bit v1, input bit v2, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] c,
                         input bit l1, input bit l2, input logic [2:0] o);
        @(negedge clk);
        #1;
        t_valid_inp1 = v1;
        t_valid_inp2 = v2;
        inp1         = a;
        inp2         = b;
        inp3         = c;
        t_last1_in   = l1;
        t_last2_in   = l2;
        op           = o;
        model_step(v1, v2, a, b, c, l1, l2, o);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, OP_NOP);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst          = 1'b1;
        t_valid_inp1 = 1'b0;
        t_valid_inp2 = 1'b0;
        t_last1_in   = 1'b0;
        t_last2_in   = 1'b0;
        scb.delete();
        m_open      = 1'b0;
        m_acc       = 0;
        m_last_fire = -100;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares every presented output against the expectation queue.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", 64'(t_valid_out), 0);
            chk("rst_last", 64'(t_last_out), 0);
            chk("rst_out", 64'(out), 0);
            chk("rst_busy", 64'(busy), 0);
            last_out = '0;
        end else begin
            while (scb.size() > 0 && scb[0].due < cyc) begin
                e = scb.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_result cyc=%0d expected=%0h due=%0d", cyc, e.val, e.due);
            end
            if (t_valid_out) begin
                if (scb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid cyc=%0d actual=%0h expected=none", cyc, out);
                end else begin
                    e = scb.pop_front();
                    chk("out_value", 64'(out), 64'(e.val));
                    chk("out_last", 64'(t_last_out), 64'(e.last));
                    chk("out_latency", 64'(cyc), 64'(e.due));
                end
                last_out = out;
            end else begin
                chk("idle_last", 64'(t_last_out), 0);
                chk("idle_hold", 64'(out), 64'(last_out));
            end
            chk("busy", 64'(busy), 64'(m_open || (m_last_fire >= cyc - int'(ML))));
        end
    end

    function automatic logic [DW-1:0] rand_val();
        int unsigned k;
        k = $urandom % 6;
        case (k)
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2, 3: return DW'($urandom_range(0, 16)) - DW'(8);
            default: return DW'($urandom);
        endcase
    endfunction

    initial begin
        rst          = 1'b1;
        inp1         = '0;
        inp2         = '0;
        inp3         = '0;
        t_valid_inp1 = 1'b0;
        t_valid_inp2 = 1'b0;
        t_last1_in   = 1'b0;
        t_last2_in   = 1'b0;
        op           = OP_NOP;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Single-beat add: 5 + -3
        drive(1, 1, 32'd5, -32'sd3, '0, 1, 0, OP_ADD);
        idle(7);

        // Mul packet of three beats
        drive(1, 1, 32'd2, 32'd3, '0, 0, 0, OP_MUL);
        drive(1, 1, 32'd4, 32'd5, '0, 0, 0, OP_MUL);
        drive(1, 1, -32'sd1, 32'd7, '0, 0, 1, OP_MUL);
        idle(7);

        // Dot product; live op changes mid-packet and must be ignored
        drive(1, 1, 32'd1, 32'd1, '0, 0, 0, OP_DOT);
        drive(1, 1, 32'd2, 32'd2, '0, 0, 0, OP_ADD);
        drive(1, 1, 32'd3, 32'd3, '0, 0, 0, OP_ADD);
        drive(1, 1, 32'd4, 32'd4, '0, 1, 0, OP_ADD);
        idle(7);

        // Accumulate with a bubble, then a one-beat packet
        drive(1, 0, 32'd10, '0, '0, 0, 0, OP_ACC);
        idle(1);
        drive(1, 0, 32'd20, '0, '0, 0, 0, OP_ACC);
        drive(1, 0, 32'd30, '0, '0, 1, 0, OP_ACC);
        drive(1, 0, 32'd7, '0, '0, 1, 0, OP_ACC);
        idle(7);

        // Signed overflow on add
        drive(1, 1, 32'h7FFF_FFFF, 32'd1, '0, 1, 0, OP_ADD);
        idle(7);

        // Back-to-back packets of different ops, zero bubbles
        drive(1, 1, 32'd3, 32'd4, 32'd100, 1, 0, OP_MACC);
        drive(1, 1, 32'd9, 32'd9, '0, 0, 1, OP_MUL);
        drive(1, 1, 32'd2, 32'd6, '0, 0, 0, OP_DOT);
        drive(1, 1, 32'd3, 32'd5, '0, 1, 0, OP_DOT);
        drive(1, 1, 32'd1, 32'd1, '0, 1, 0, OP_NOP);
        drive(1, 1, -32'sd50, 32'd8, '0, 0, 1, OP_ADD);
        idle(7);

        // Reset in the middle of an accumulate packet
        drive(1, 0, 32'd3, '0, '0, 0, 0, OP_ACC);
        drive(1, 0, 32'd4, '0, '0, 0, 0, OP_ACC);
        drive(1, 0, 32'd5, '0, '0, 0, 0, OP_ACC);
        do_reset();
        idle(2);
        drive(1, 0, 32'd1, '0, '0, 0, 0, OP_ACC);
        drive(1, 0, 32'd2, '0, '0, 1, 0, OP_ACC);
        idle(7);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            if ($urandom % 600 == 0) begin
                do_reset();
            end else if ($urandom % 8 == 0) begin
                idle(1);
            end else begin
                drive(($urandom % 4) != 0, ($urandom % 4) != 0,
                      rand_val(), rand_val(), rand_val(),
                      ($urandom % 5) == 0, ($urandom % 7) == 0,
                      3'($urandom_range(0, 7)));
            end
        end
        idle(LAT + 4);

        checks++;
        if (scb.size() != 0) begin
            failures++;
            $display("FAIL drain actual_pending=%0d expected=0", scb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_stream_macc.md
Name: pe_stream_macc

Overview:
Parametrised integer stream processing element for the CGRA fabric, the successor of the fixed double-precision PE.
- Element-wise ops: add, mul, multiply-add.
- Packet reductions, terminated by tlast: accumulate, dot product.
- Op is latched once per packet.
- All ops share one uniform pipeline latency, so op changes between packets never reorder or collide on the output.

Parameters:
DWIDTH, 32, operand/result width in bits, signed two's complement
MUL_LAT, 4, multiplier pipeline depth in cycles (>=1); total latency L = MUL_LAT+1

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
inp1  input  DWIDTH  stream operand A
inp2  input  DWIDTH  stream operand B
inp3  input  DWIDTH  static operand C (macc addend), sampled on each fired beat
t_valid_inp1  input  1  inp1 valid
t_valid_inp2  input  1  inp2 valid
t_last1_in  input  1  last beat flag from inp1 source
t_last2_in  input  1  last beat flag from inp2 source
op  input  3  000 add, 001 acc, 010 mul, 011 macc, 100 dot, others NOP
out  output  DWIDTH  result
t_valid_out  output  1  result valid
t_last_out  output  1  result is last of packet
busy  output  1  packet open or any beat in flight

Behaviour:
- No backpressure; a beat is consumed whenever it fires.
- Fire condition:
  - acc: t_valid_inp1 alone.
  - All other ops (including NOP): t_valid_inp1 & t_valid_inp2.
  - Fire is evaluated with the latched op mid-packet, and with the live op on a packet's first beat.
- last = (t_last1_in | t_last2_in) & fire.
- Packet state:
  - IDLE: on fire, latch op into pkt_op and go to OPEN.
  - OPEN: live op is ignored.
  - On a fire with last, return to IDLE after that beat.
  - A 1-beat packet latches and closes in the same cycle.
- pkt_op, valid, last and a first-beat flag travel with each beat through the pipeline.
- Stage 0 to stage MUL_LAT: product p = inp1*inp2 (full 2*DWIDTH internally). inp1, inp2 and inp3 are delay-matched.
- Final stage (registered, output at L cycles after fire):
  - add: inp1+inp2.
  - mul: p.
  - macc: p+inp3.
  - Each of these outputs one result per fired beat; t_last_out = beat's last.
  - acc: acc_next = (first ? 0 : acc_reg) + inp1.
  - dot: acc_next = (first ? 0 : acc_reg) + p.
  - acc/dot: acc_reg <= acc_next every fired beat. Output only on the last beat: out = acc_next, t_valid_out=1, t_last_out=1.
  - NOP: no output; packet tracking still runs.
- Arithmetic: results wrap modulo 2^DWIDTH; mul keeps the low DWIDTH bits of p.
- Idle gaps inside a packet are allowed; acc_reg holds across bubbles.
- Back-to-back packets with different ops are legal with zero bubbles; every result still appears exactly L cycles after its fire.
- When t_valid_out=0: out holds its last value and t_last_out=0.
- busy = OPEN | any valid in pipeline.
- Reset (any time, including mid-packet):
  - out=0, t_valid_out=0, t_last_out=0, busy=0.
  - Pipeline valids cleared, acc_reg=0, state IDLE.
  - No stale partial sum is ever emitted after reset.

Optional Feature:
- Macro PE_SAT_EN.
- Defined: add, macc and acc/dot results clamp to 2^(DWIDTH-1)-1 or -2^(DWIDTH-1) on signed overflow. For mul, the full product is compared against these bounds before clamping. The accumulator keeps the saturated value.
- Undefined: all results wrap; no saturation logic is synthesised.

Test Plan:
1. Add, DWIDTH=32, MUL_LAT=4: fire cycle 0, inp1=5, inp2=-3, last=1 -> out=2, t_valid_out=1, t_last_out=1 at cycle 5.
2. Mul, 3 beats (2,3),(4,5),(-1,7) on cycles 0-2, last on beat 3 -> out 6, 20, -7 at cycles 5-7; t_last_out only at cycle 7.
3. Dot, 4 beats (1,1),(2,2),(3,3),(4,4), op switched to 000 at beat 2, last on beat 4 (cycle 3) -> single out=30 with t_last_out=1 at cycle 8; no other valid output.
4. Acc: inp1 10, bubble, 20, 30 (last), with inp2 invalid throughout -> one out=60. Next 1-beat packet inp1=7 last -> out=7 (accumulator cleared).
5. Overflow: add 0x7FFFFFFF + 1 -> 0x80000000 without PE_SAT_EN, 0x7FFFFFFF with it.
6. Reset: acc beats 3,4,5 without last, pulse rst for 1 cycle, then acc packet 1,2 (last) -> out=3 only; t_valid_out stays 0 during and right after reset; busy=0 after reset.
